// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select codes
// and the default reset/trap vectors.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_RET    = 3'd3,
        SEL_TRAP   = 3'd4
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the fetch control and the PC sequencer.
interface pc_sequencer_if #(
    parameter int REG_BITS  = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                stall;
    logic                trap;
    logic                branch;
    logic [REG_BITS-1:0] branch_target;
    logic                jump;
    logic                call;
    logic                ret;
    logic [REG_BITS-1:0] jump_target;
    logic [REG_BITS-1:0] pc;
    logic [REG_BITS-1:0] pc_next;
    logic [REG_BITS-1:0] pc_plus;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_underflow;

    modport master (
        output stall, trap, branch, branch_target, jump, call, ret, jump_target,
        input  pc, pc_next, pc_plus, ras_count, ras_underflow
    );

    modport slave (
        input  stall, trap, branch, branch_target, jump, call, ret, jump_target,
        output pc, pc_next, pc_plus, ras_count, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack with saturating count; a push at full
// overwrites the oldest entry, and push+pop together replaces the top.
module ras_stack #(
    parameter int REG_BITS  = 32,
    parameter int RAS_DEPTH = 4,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic [REG_BITS-1:0] push_data,
    output logic [REG_BITS-1:0] top,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full
);
    logic [REG_BITS-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [PTR_W-1:0]    top_idx_s;
    logic                pop_ok_s;

    // ptr_r names the next free slot, so the top lives one below it
    assign top_idx_s = ptr_r - PTR_W'(1);
    assign top       = mem_r[top_idx_s];
    assign count     = count_r;
    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(RAS_DEPTH));
    assign pop_ok_s  = pop && !empty;

    // Entry storage: contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push && pop_ok_s) begin
            mem_r[top_idx_s] <= push_data;
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
        end
    end

    // Pointer and saturating occupancy count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r   <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else begin
            case ({push, pop_ok_s})
                2'b10: begin
                    ptr_r   <= ptr_r + PTR_W'(1);
                    count_r <= full ? count_r : count_r + CNT_W'(1);
                end
                2'b01: begin
                    ptr_r   <= top_idx_s;
                    count_r <= count_r - CNT_W'(1);
                end
                default: begin
                    ptr_r   <= ptr_r;
                    count_r <= count_r;
                end
            endcase
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC select, target alignment,
// the PC register and a return-address stack for call/return.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  REG_BITS     = 32,
    parameter int                  INSTR_BYTES  = 4,
    parameter logic [REG_BITS-1:0] RESET_VECTOR = REG_BITS'(DEFAULT_RESET_VECTOR),
    parameter logic [REG_BITS-1:0] TRAP_VECTOR  = REG_BITS'(DEFAULT_TRAP_VECTOR),
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_sequencer_if.slave  bus
);
    localparam int                  CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam logic [REG_BITS-1:0] ALIGN_MASK = ~(REG_BITS'(INSTR_BYTES - 1));

    logic [REG_BITS-1:0] pc_r;
    logic [REG_BITS-1:0] pc_plus_s;
    logic [REG_BITS-1:0] target_s;
    logic [REG_BITS-1:0] pc_next_s;
    logic [REG_BITS-1:0] ras_top_s;
    logic [CNT_W-1:0]    ras_count_s;
    logic                ras_empty_s;
    logic                ras_full_s;
    logic                ret_ok_s;
    logic                advance_s;
    pc_sel_e             sel_s;

    assign pc_plus_s = pc_r + REG_BITS'(INSTR_BYTES);
    assign ret_ok_s  = bus.ret && !ras_empty_s;
    // A trap always moves the PC, even while stalled, but never touches the RAS
    assign advance_s = bus.trap || !bus.stall;

    // Next-PC source priority: trap > ret > call/jump > branch > sequential
    always_comb begin
        sel_s = SEL_SEQ;
        if (bus.trap) begin
            sel_s = SEL_TRAP;
        end else if (ret_ok_s) begin
            sel_s = SEL_RET;
        end else if (bus.call || bus.jump) begin
            sel_s = SEL_JUMP;
        end else if (bus.branch) begin
            sel_s = SEL_BRANCH;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Source mux followed by instruction alignment of the chosen target
    always_comb begin
        target_s = pc_plus_s;
        case (sel_s)
            SEL_TRAP:   target_s = TRAP_VECTOR;
            SEL_RET:    target_s = ras_top_s;
            SEL_JUMP:   target_s = bus.jump_target;
            SEL_BRANCH: target_s = bus.branch_target;
            SEL_SEQ:    target_s = pc_plus_s;
            default:    target_s = pc_plus_s;
        endcase
        pc_next_s = target_s & ALIGN_MASK;
    end

    // PC register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_VECTOR;
        end else if (advance_s) begin
            pc_r <= pc_next_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    ras_stack #(
        .REG_BITS  (REG_BITS),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.call && !bus.trap && !bus.stall),
        .pop       (bus.ret && !bus.trap && !bus.stall),
        .push_data (pc_plus_s),
        .top       (ras_top_s),
        .count     (ras_count_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s)
    );

    assign bus.pc            = pc_r;
    assign bus.pc_next       = pc_next_s;
    assign bus.pc_plus       = pc_plus_s;
    assign bus.ras_count     = ras_count_s;
    assign bus.ras_underflow = bus.ret && ras_empty_s;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequencing, branch/jump priority,
// alignment, wrap, stall/trap, call/return and RAS overflow behaviour.
module tb_pc_sequencer;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    pc_sequencer_if #(.REG_BITS(32), .RAS_DEPTH(4)) bus ();

    pc_sequencer #(
        .REG_BITS     (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080),
        .RAS_DEPTH    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.trap = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
        bus.call = 1'b0; bus.ret = 1'b0;
        bus.branch_target = 32'h0; bus.jump_target = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_jump(input logic [31:0] t);
        bus.jump = 1'b1; bus.jump_target = t;
        step();
    endtask

    task automatic do_call(input logic [31:0] t);
        bus.call = 1'b1; bus.jump_target = t;
        step();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        idle();
        reset_n = 1'b0;
        #12;
        check("reset_pc", bus.pc, 32'h0);
        check("reset_count", 32'(bus.ras_count), 32'h0);
        reset_n = 1'b1;

        // Sequential increments
        step(); check("seq1", bus.pc, 32'h4);
        step(); check("seq2", bus.pc, 32'h8);
        step(); check("seq3", bus.pc, 32'hC);

        // Asynchronous reset away from the edge
        #3 reset_n = 1'b0;
        #1 check("async_reset", bus.pc, 32'h0);
        #2 reset_n = 1'b1;

        // Branch with misaligned target
        bus.branch = 1'b1; bus.branch_target = 32'h103;
        step(); check("branch_align", bus.pc, 32'h100);

        // Jump beats branch
        bus.jump = 1'b1; bus.jump_target = 32'h200;
        bus.branch = 1'b1; bus.branch_target = 32'h300;
        step(); check("jump_over_branch", bus.pc, 32'h200);

        // Wrap-around
        do_jump(32'hFFFF_FFFC);
        check("at_top", bus.pc, 32'hFFFF_FFFC);
        check("pc_plus_wrap", bus.pc_plus, 32'h0);
        step(); check("wrap", bus.pc, 32'h0);
        step(); check("after_wrap", bus.pc, 32'h4);

        // Stall with branch: pc holds, pc_next shows the target
        bus.stall = 1'b1; bus.branch = 1'b1; bus.branch_target = 32'h40;
        #1 check("stall_pc_next", bus.pc_next, 32'h40);
        step(); check("stall_hold", bus.pc, 32'h4);

        // Call / return
        do_jump(32'h10);
        do_call(32'h100);
        check("call_pc", bus.pc, 32'h100);
        check("call_count", 32'(bus.ras_count), 32'h1);
        bus.stall = 1'b1; bus.call = 1'b1; bus.jump_target = 32'h700;
        step();
        check("stall_call_pc", bus.pc, 32'h100);
        check("stall_call_count", 32'(bus.ras_count), 32'h1);
        bus.ret = 1'b1;
        #1 check("ret_no_underflow", 32'(bus.ras_underflow), 32'h0);
        step();
        check("ret_pc", bus.pc, 32'h14);
        check("ret_count", 32'(bus.ras_count), 32'h0);
        bus.ret = 1'b1;
        #1 check("underflow_flag", 32'(bus.ras_underflow), 32'h1);
        step();
        check("underflow_pc", bus.pc, 32'h18);
        check("underflow_count", 32'(bus.ras_count), 32'h0);

        // RAS overflow: five nested calls from a fresh reset
        #3 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        do_call(32'h100); check("ovf_c1", 32'(bus.ras_count), 32'h1);
        do_call(32'h200); check("ovf_c2", 32'(bus.ras_count), 32'h2);
        do_call(32'h300); check("ovf_c3", 32'(bus.ras_count), 32'h3);
        do_call(32'h400); check("ovf_c4", 32'(bus.ras_count), 32'h4);
        do_call(32'h500); check("ovf_c5", 32'(bus.ras_count), 32'h4);
        check("ovf_pc", bus.pc, 32'h500);
        bus.ret = 1'b1; step(); check("ovf_r1", bus.pc, 32'h404);
        bus.ret = 1'b1; step(); check("ovf_r2", bus.pc, 32'h304);
        bus.ret = 1'b1; step(); check("ovf_r3", bus.pc, 32'h204);
        bus.ret = 1'b1; step(); check("ovf_r4", bus.pc, 32'h104);
        check("ovf_empty", 32'(bus.ras_count), 32'h0);
        bus.ret = 1'b1;
        #1 check("ovf_underflow", 32'(bus.ras_underflow), 32'h1);
        step(); check("ovf_r5_pc", bus.pc, 32'h108);

        // Call and ret in the same cycle replace the top
        do_jump(32'h20);
        do_call(32'h50);
        check("cr_setup_pc", bus.pc, 32'h50);
        bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = 32'h500;
        step();
        check("cr_pc", bus.pc, 32'h24);
        check("cr_count", 32'(bus.ras_count), 32'h1);

        // Stall + trap (+ ret ignored): pc to trap vector, RAS untouched
        bus.stall = 1'b1; bus.trap = 1'b1; bus.ret = 1'b1;
        step();
        check("trap_pc", bus.pc, 32'h80);
        check("trap_count", 32'(bus.ras_count), 32'h1);
        bus.ret = 1'b1; step();
        check("cr_top_pc", bus.pc, 32'h54);
        check("cr_top_count", 32'(bus.ras_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
